// File: rtl/fht_pkg.sv
// Shared types and default geometry for the FHT sequencer.
// Module parameters default to these values; N, P and N/4 follow from A_BIT.
package fht_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } fht_state_t;

    localparam int FHT_A_BIT = 10;
    localparam int FHT_LAT   = 4;
    localparam int FHT_N     = 1 << FHT_A_BIT;
    localparam int FHT_P     = FHT_A_BIT - 1;
    localparam int FHT_Q     = FHT_N / 4;

endpackage

// File: rtl/fht_addr_gen.sv
// Butterfly read-address and twiddle-index generator; purely combinational (0 cycles).
// No backpressure: outputs follow stage/cnt. FHT_COEF_QUARTER_EN folds the coefficient index.
module fht_addr_gen
    import fht_pkg::*;
#(
    parameter int A_BIT = FHT_A_BIT,
    parameter int SW    = 4,
    parameter int CW    = 9
) (
    input  logic [SW-1:0]    stage,
    input  logic [CW-1:0]    cnt,
    output logic [A_BIT-1:0] rd0,
    output logic [A_BIT-1:0] rd1,
    output logic [A_BIT-1:0] rd2,
    output logic [A_BIT-1:0] rd3,
    output logic [A_BIT-1:0] coef,
    output logic             fold
);

    logic [A_BIT-1:0] idx;
    logic [A_BIT-1:0] hh;
    logic [A_BIT-1:0] h;
    logic [A_BIT-1:0] mask;
    logic [A_BIT-1:0] k;
    logic [A_BIT-1:0] g;
    logic [A_BIT-1:0] c;
    logic [SW-1:0]    csh;

    // A group spans 2H points in H/2 cycles, so low stage bits of cnt are k
    // and the remaining bits times four give the group base g.
    assign idx  = A_BIT'(cnt);
    assign hh   = A_BIT'(1) << stage;
    assign h    = hh << 1;
    assign mask = hh - A_BIT'(1);
    assign k    = idx & mask;
    assign g    = (idx & ~mask) << 2;
    assign csh  = SW'(A_BIT - 2) - stage;
    assign c    = k << csh;

    // Pass 0 falls out of the same formulas: mask=0, H/2=1, H=2.
    always_comb begin
        rd0 = g;
        rd1 = g + hh;
        rd2 = g + h;
        rd3 = g + h + hh;
        if (k != '0) begin
            rd0 = g + k;
            rd1 = g + h - k;
            rd2 = g + h + k;
            rd3 = g + (h << 1) - k;
        end
    end

`ifdef FHT_COEF_QUARTER_EN
    logic [A_BIT-1:0] quarter;
    logic [A_BIT-1:0] eighth;

    assign quarter = A_BIT'(1) << (A_BIT - 2);
    assign eighth  = quarter >> 1;

    always_comb begin
        coef = c;
        fold = 1'b0;
        if (c >= eighth) begin
            coef = quarter - c;
            fold = 1'b1;
        end
    end
`else
    assign coef = c;
    assign fold = 1'b0;
`endif

endmodule

// File: rtl/fht_control.sv
// FHT pass sequencer: read/coef addresses per cycle, write addresses delayed by LAT, bank write enables.
// Reads are combinational from the counters; writes trail reads by LAT cycles. No backpressure; iSTART ignored while busy.
// Optional macro FHT_COEF_QUARTER_EN enables quarter-wave coefficient folding.
module fht_control
    import fht_pkg::*;
#(
    parameter int A_BIT = FHT_A_BIT,
    parameter int LAT   = FHT_LAT
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    output logic             oST_ZERO,
    output logic             oST_LAST,
    output logic             o2ND_PART_SUBSECTOR,
    output logic [A_BIT-1:0] oSECTOR,
    output logic [A_BIT-1:0] oADDR_RD_0,
    output logic [A_BIT-1:0] oADDR_RD_1,
    output logic [A_BIT-1:0] oADDR_RD_2,
    output logic [A_BIT-1:0] oADDR_RD_3,
    output logic [A_BIT-1:0] oADDR_WR,
    output logic [A_BIT-1:0] oADDR_WR_BIAS,
    output logic [A_BIT-1:0] oADDR_COEF,
    output logic             oWE_A,
    output logic             oWE_B,
    output logic             oRDY
);

    localparam int N  = 1 << A_BIT;
    localparam int P  = A_BIT - 1;
    localparam int Q  = N / 4;
    localparam int SW = $clog2(P + 1);
    localparam int CW = $clog2(Q + LAT + 1);

    localparam logic [CW-1:0] RUN_END    = CW'(Q - 1);
    localparam logic [CW-1:0] DRAIN_END  = CW'(Q + LAT - 1);
    localparam logic [CW-1:0] WE_ON      = CW'(LAT - 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(P - 1);
    localparam logic [SW-1:0] PENULT     = SW'(P - 2);

    fht_state_t    state;
    logic [SW-1:0] stage_num;
    logic [CW-1:0] cnt_stage_time;

    logic [A_BIT-1:0] gen_rd0, gen_rd1, gen_rd2, gen_rd3, gen_coef;
    logic             gen_fold;
    logic             run;

    fht_addr_gen #(
        .A_BIT (A_BIT),
        .SW    (SW),
        .CW    (CW)
    ) u_addr_gen (
        .stage (stage_num),
        .cnt   (cnt_stage_time),
        .rd0   (gen_rd0),
        .rd1   (gen_rd1),
        .rd2   (gen_rd2),
        .rd3   (gen_rd3),
        .coef  (gen_coef),
        .fold  (gen_fold)
    );

    // Read side is only meaningful during RUN; elsewhere drive zeros so the
    // delay line flushes clean addresses behind the last read.
    assign run                 = (state == ST_RUN);
    assign oADDR_RD_0          = run ? gen_rd0  : '0;
    assign oADDR_RD_1          = run ? gen_rd1  : '0;
    assign oADDR_RD_2          = run ? gen_rd2  : '0;
    assign oADDR_RD_3          = run ? gen_rd3  : '0;
    assign oADDR_COEF          = run ? gen_coef : '0;
    assign o2ND_PART_SUBSECTOR = run & gen_fold;

    always_comb begin
        oSECTOR = '0;
        if (state != ST_IDLE) begin
            oSECTOR = (stage_num == '0) ? A_BIT'(1) : (A_BIT'(1) << (stage_num + 1'b1));
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state          <= ST_IDLE;
            stage_num      <= '0;
            cnt_stage_time <= '0;
            oRDY           <= 1'b1;
            oST_ZERO       <= 1'b0;
            oST_LAST       <= 1'b0;
            oWE_A          <= 1'b0;
            oWE_B          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iSTART) begin
                        state          <= ST_RUN;
                        stage_num      <= '0;
                        cnt_stage_time <= '0;
                        oRDY           <= 1'b0;
                        oST_ZERO       <= 1'b1;
                        oST_LAST       <= (P == 1);
                    end
                end
                ST_RUN: begin
                    cnt_stage_time <= cnt_stage_time + 1'b1;
                    if (cnt_stage_time == RUN_END) begin
                        state <= ST_DRAIN;
                    end
                    // Writes start LAT cycles after the first read of the pass.
                    if (cnt_stage_time >= WE_ON) begin
                        oWE_A <= stage_num[0];
                        oWE_B <= ~stage_num[0];
                    end
                end
                ST_DRAIN: begin
                    if (cnt_stage_time == DRAIN_END) begin
                        cnt_stage_time <= '0;
                        oWE_A          <= 1'b0;
                        oWE_B          <= 1'b0;
                        oST_ZERO       <= 1'b0;
                        if (stage_num == LAST_STAGE) begin
                            state     <= ST_IDLE;
                            stage_num <= '0;
                            oRDY      <= 1'b1;
                            oST_LAST  <= 1'b0;
                        end else begin
                            state     <= ST_RUN;
                            stage_num <= stage_num + 1'b1;
                            oST_LAST  <= (stage_num == PENULT);
                        end
                    end else begin
                        cnt_stage_time <= cnt_stage_time + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [A_BIT-1:0] dly_rd0 [LAT];
    logic [A_BIT-1:0] dly_rd1 [LAT];

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int i = 0; i < LAT; i++) begin
                dly_rd0[i] <= '0;
                dly_rd1[i] <= '0;
            end
        end else begin
            dly_rd0[0] <= oADDR_RD_0;
            dly_rd1[0] <= oADDR_RD_1;
            for (int i = 1; i < LAT; i++) begin
                dly_rd0[i] <= dly_rd0[i-1];
                dly_rd1[i] <= dly_rd1[i-1];
            end
        end
    end

    assign oADDR_WR      = dly_rd0[LAT-1];
    assign oADDR_WR_BIAS = dly_rd1[LAT-1];

endmodule

// File: tb/tb_fht_control.sv
// Directed bench for fht_control at A_BIT=10, LAT=4: reset, full transform timing, busy start, abort and restart.
module tb_fht_control;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       st_zero, st_last, fold;
    logic [9:0] sector, rd0, rd1, rd2, rd3, wr, wr_bias, coef;
    logic       we_a, we_b, rdy;

    int checks;
    int failures;

    fht_control dut (
        .iCLK                (clk),
        .iRESET              (rst_n),
        .iSTART              (start),
        .oST_ZERO            (st_zero),
        .oST_LAST            (st_last),
        .o2ND_PART_SUBSECTOR (fold),
        .oSECTOR             (sector),
        .oADDR_RD_0          (rd0),
        .oADDR_RD_1          (rd1),
        .oADDR_RD_2          (rd2),
        .oADDR_RD_3          (rd3),
        .oADDR_WR            (wr),
        .oADDR_WR_BIAS       (wr_bias),
        .oADDR_COEF          (coef),
        .oWE_A               (we_a),
        .oWE_B               (we_b),
        .oRDY                (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns on the negedge of the first RUN cycle (cycle 0 of pass 0).
    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [39:0] rd_all;
        rst_n = 1'b0;
        start = 1'b0;
        #12;
        rd_all = {rd0, rd1, rd2, rd3};
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy: got %b expected 1", rdy); end
        checks++; if ({we_a, we_b, st_zero, st_last, fold} !== 5'b0) begin failures++; $display("FAIL reset_flags: got %b expected 00000", {we_a, we_b, st_zero, st_last, fold}); end
        checks++; if (rd_all !== 40'd0) begin failures++; $display("FAIL reset_rd: got %h expected 0", rd_all); end
        checks++; if ({sector, wr, wr_bias, coef} !== 40'd0) begin failures++; $display("FAIL reset_misc_addr: got %h expected 0", {sector, wr, wr_bias, coef}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({rdy, we_a, we_b, st_zero} !== 4'b1000) begin failures++; $display("FAIL idle_after_reset: got %b expected 1000", {rdy, we_a, we_b, st_zero}); end
        checks++; if ({rd0, rd1, sector} !== 30'd0) begin failures++; $display("FAIL idle_addr: got %h expected 0", {rd0, rd1, sector}); end
    endtask

    task automatic test_full_transform();
        int we_b_p0, we_a_p1, first_we, both_high, rdy_early;
        logic [39:0] rd_all;
        we_b_p0 = 0; we_a_p1 = 0; first_we = -1; both_high = 0; rdy_early = 0;
        start_pulse();
        for (int c = 0; c <= 2341; c++) begin
            rd_all = {rd0, rd1, rd2, rd3};
            if (c < 260 && we_b) begin
                we_b_p0++;
                if (first_we < 0) first_we = c;
            end
            if (c >= 260 && c < 520 && we_a) we_a_p1++;
            if (we_a && we_b) both_high++;
            if (c < 2340 && rdy) rdy_early++;
            case (c)
                0: begin
                    checks++; if ({rdy, st_zero, st_last} !== 3'b010) begin failures++; $display("FAIL start_flags: got %b expected 010", {rdy, st_zero, st_last}); end
                    checks++; if (rd_all !== {10'd0, 10'd1, 10'd2, 10'd3}) begin failures++; $display("FAIL p0_rd_j0: got %h expected 0,1,2,3", rd_all); end
                    checks++; if ({sector, coef} !== {10'd1, 10'd0}) begin failures++; $display("FAIL p0_sector_coef: got %h expected sector 1 coef 0", {sector, coef}); end
                end
                1: begin
                    checks++; if (rd_all !== {10'd4, 10'd5, 10'd6, 10'd7}) begin failures++; $display("FAIL p0_rd_j1: got %h expected 4,5,6,7", rd_all); end
                end
                4: begin
                    checks++; if ({wr, wr_bias} !== {10'd0, 10'd1}) begin failures++; $display("FAIL wr_delay_j0: got %h expected 0,1", {wr, wr_bias}); end
                end
                5: begin
                    checks++; if ({wr, wr_bias} !== {10'd4, 10'd5}) begin failures++; $display("FAIL wr_delay_j1: got %h expected 4,5", {wr, wr_bias}); end
                end
                260: begin
                    checks++; if (rd_all !== {10'd0, 10'd2, 10'd4, 10'd6}) begin failures++; $display("FAIL p1_rd_c0: got %h expected 0,2,4,6", rd_all); end
                    checks++; if ({sector, st_zero} !== {10'd4, 1'b0}) begin failures++; $display("FAIL p1_sector: got %h expected sector 4 st_zero 0", {sector, st_zero}); end
                end
                261: begin
                    checks++; if (rd_all !== {10'd1, 10'd3, 10'd5, 10'd7}) begin failures++; $display("FAIL p1_rd_c1: got %h expected 1,3,5,7", rd_all); end
                end
                262: begin
                    checks++; if (rd_all !== {10'd8, 10'd10, 10'd12, 10'd14}) begin failures++; $display("FAIL p1_rd_c2: got %h expected 8,10,12,14", rd_all); end
                end
                2080: begin
                    checks++; if (rd_all !== {10'd0, 10'd256, 10'd512, 10'd768}) begin failures++; $display("FAIL p8_rd_k0: got %h expected 0,256,512,768", rd_all); end
                    checks++; if ({st_last, sector} !== {1'b1, 10'd512}) begin failures++; $display("FAIL p8_last_sector: got %h expected last 1 sector 512", {st_last, sector}); end
                end
                2081: begin
                    checks++; if (rd_all !== {10'd1, 10'd511, 10'd513, 10'd1023}) begin failures++; $display("FAIL p8_rd_k1: got %h expected 1,511,513,1023", rd_all); end
                    checks++; if ({fold, coef} !== {1'b0, 10'd1}) begin failures++; $display("FAIL p8_coef_k1: got %h expected fold 0 coef 1", {fold, coef}); end
                end
                2280: begin
`ifdef FHT_COEF_QUARTER_EN
                    checks++; if ({fold, coef} !== {1'b1, 10'd56}) begin failures++; $display("FAIL p8_coef_k200: got fold %b coef %0d expected fold 1 coef 56", fold, coef); end
`else
                    checks++; if ({fold, coef} !== {1'b0, 10'd200}) begin failures++; $display("FAIL p8_coef_k200: got fold %b coef %0d expected fold 0 coef 200", fold, coef); end
`endif
                end
                2339: begin
                    checks++; if ({rdy, we_b} !== 2'b01) begin failures++; $display("FAIL last_drain: got rdy,we_b %b expected 01", {rdy, we_b}); end
                    start = 1'b1;
                end
                2340: begin
                    start = 1'b0;
                    checks++; if ({rdy, we_a, we_b} !== 3'b100) begin failures++; $display("FAIL done: got rdy,we_a,we_b %b expected 100", {rdy, we_a, we_b}); end
                end
                2341: begin
                    checks++; if ({rdy, st_zero} !== 2'b10) begin failures++; $display("FAIL start_at_done_ignored: got %b expected 10", {rdy, st_zero}); end
                end
                default: ;
            endcase
            if (c < 2341) @(negedge clk);
        end
        checks++; if (we_b_p0 !== 256) begin failures++; $display("FAIL p0_we_b_count: got %0d expected 256", we_b_p0); end
        checks++; if (first_we !== 4) begin failures++; $display("FAIL p0_we_start: got %0d expected 4", first_we); end
        checks++; if (we_a_p1 !== 256) begin failures++; $display("FAIL p1_we_a_count: got %0d expected 256", we_a_p1); end
        checks++; if (both_high !== 0) begin failures++; $display("FAIL we_exclusive: got %0d expected 0", both_high); end
        checks++; if (rdy_early !== 0) begin failures++; $display("FAIL rdy_early: got %0d expected 0", rdy_early); end
    endtask

    task automatic test_busy_abort_restart();
        int we_seen;
        we_seen = 0;
        start_pulse();
        for (int c = 0; c < 1320; c++) begin
            if (c == 790) start = 1'b1;
            if (c == 791) start = 1'b0;
            if (c == 793) begin
                checks++; if ({rdy, st_zero, sector} !== {1'b0, 1'b0, 10'd16}) begin failures++; $display("FAIL busy_start_ignored: got %h expected rdy 0 zero 0 sector 16", {rdy, st_zero, sector}); end
            end
            @(negedge clk);
        end
        checks++; if ({we_a, we_b, sector} !== {2'b10, 10'd64}) begin failures++; $display("FAIL p5_before_abort: got %h expected we_a 1 sector 64", {we_a, we_b, sector}); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({rdy, we_a, we_b, st_zero, st_last} !== 5'b10000) begin failures++; $display("FAIL abort_flags: got %b expected 10000", {rdy, we_a, we_b, st_zero, st_last}); end
        checks++; if ({rd0, rd1, coef, sector, wr} !== 50'd0) begin failures++; $display("FAIL abort_addr: got %h expected 0", {rd0, rd1, coef, sector, wr}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (we_a || we_b) we_seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (we_a || we_b || !rdy) we_seen++;
        end
        checks++; if (we_seen !== 0) begin failures++; $display("FAIL no_writes_after_abort: got %0d expected 0", we_seen); end
        start_pulse();
        checks++; if ({rdy, st_zero, sector} !== {1'b0, 1'b1, 10'd1}) begin failures++; $display("FAIL restart_pass0: got %h expected rdy 0 zero 1 sector 1", {rdy, st_zero, sector}); end
        checks++; if ({rd0, rd1, rd2, rd3} !== {10'd0, 10'd1, 10'd2, 10'd3}) begin failures++; $display("FAIL restart_rd: got %h expected 0,1,2,3", {rd0, rd1, rd2, rd3}); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        test_reset();
        test_full_transform();
        test_busy_abort_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fht_control.md
FHT_CONTROL -- requirements
Module: fht_control

Interface
REQ-001 Parameter A_BIT, default 10, address width; transform size N = 2^A_BIT points.
REQ-002 Parameter LAT, default 4, datapath latency in cycles from read address to write address.
REQ-003 iCLK  in  1  single clock; all logic on rising edge.
REQ-004 iRESET  in  1  asynchronous, active-low reset.
REQ-005 iSTART  in  1  one-cycle start pulse; honoured only while oRDY=1.
REQ-006 oST_ZERO  out  1  high during pass 0.
REQ-007 oST_LAST  out  1  high during the final pass.
REQ-008 o2ND_PART_SUBSECTOR  out  1  coefficient quarter-wave fold flag.
REQ-009 oSECTOR  out  A_BIT  current half-span H, held constant for a whole pass.
REQ-010 oADDR_RD_0..oADDR_RD_3  out  A_BIT each  four butterfly read addresses.
REQ-011 oADDR_WR, oADDR_WR_BIAS  out  A_BIT each  oADDR_RD_0 and oADDR_RD_1 delayed by LAT cycles.
REQ-012 oADDR_COEF  out  A_BIT  twiddle ROM address, aligned with the read addresses.
REQ-013 oWE_A, oWE_B  out  1 each  bank write enables.
REQ-014 oRDY  out  1  idle/done.

Function
REQ-015 FSM states: IDLE, RUN, DRAIN. IDLE+iSTART -> RUN next cycle, with oRDY dropping to 0.
REQ-016 A transform has P = A_BIT-1 passes, with internal counter stage_num = 0..P-1.
REQ-017 Each pass has N/4 read cycles (RUN) followed by LAT drain cycles (DRAIN); internal counter cnt_stage_time counts 0..N/4+LAT-1 and restarts at each pass.
REQ-018 Pass 0 cycle j: RD0..RD3 = 4j, 4j+1, 4j+2, 4j+3; oADDR_COEF = 0; oSECTOR = 1.
REQ-019 Pass p>=1: H = 2^(p+1); groups g = 0, 2H, 4H, ... (outer loop); k = 0..H/2-1 ascending (inner loop).
REQ-020 Pass p>=1 at k=0: RD = g, g+H/2, g+H, g+3H/2. At k>=1: RD = g+k, g+H-k, g+H+k, g+2H-k.
REQ-021 Pass p>=1 coefficient: raw index c = k*N/(2H).
REQ-022 Write addresses: datapath writes results to oADDR_WR, oADDR_WR_BIAS, oADDR_WR+oSECTOR and oADDR_WR_BIAS+oSECTOR.
REQ-023 Write enable asserts exactly N/4 cycles per pass, starting LAT cycles after the first read cycle.
REQ-024 Even passes read bank A and assert oWE_B; odd passes read bank B and assert oWE_A; the two are never high together.
REQ-025 The next pass's reads begin the cycle after DRAIN ends; no overlap between passes.
REQ-026 After the last DRAIN: FSM -> IDLE, oRDY=1 in the same cycle the write enables drop, and the final result is in bank A if P is even, else bank B.
REQ-027 iSTART while busy is ignored; iSTART coincident with the return to IDLE is also ignored.
REQ-028 Address arithmetic is modulo 2^A_BIT; internal counters are wide enough for N/4+LAT.

Reset
REQ-029 iRESET low -> immediately IDLE, with oRDY=1.
REQ-030 Under reset, all addresses, oSECTOR, oWE_A/B, oST_*, o2ND_PART_SUBSECTOR = 0, and both counters = 0.
REQ-031 Reset mid-transform aborts without further writes; a new iSTART after release restarts from pass 0.

Configuration
REQ-032 Macro FHT_COEF_QUARTER_EN defined: if c >= N/8 then oADDR_COEF = N/4-c and o2ND_PART_SUBSECTOR = 1; else oADDR_COEF = c and o2ND_PART_SUBSECTOR = 0.
REQ-033 FHT_COEF_QUARTER_EN undefined: oADDR_COEF = c, and o2ND_PART_SUBSECTOR is tied to 0.

Structure
REQ-034 Shared package fht_pkg holds the FSM state enum, default A_BIT/LAT, and derived constants N, P, N/4.
REQ-035 One sub-module, fht_addr_gen (combinational generation of RD0..3 and coefficient from pass, g, k); the delay line and FSM stay in fht_control.

Verification
REQ-036 Reset then idle: oRDY=1, all outputs 0; iSTART pulse -> oRDY=0 next cycle, oST_ZERO=1, first RD = 0,1,2,3.
REQ-037 Pass 1 (H=4): first three cycles RD = (0,2,4,6), (1,3,5,7), (8,10,12,14); oSECTOR=4.
REQ-038 Pass 8 (H=512, N=1024): RD = (0,256,512,768), then (1,511,513,1023) with raw coefficient 1; oST_LAST=1.
REQ-039 Timing: 256 oWE_B cycles in pass 0, starting 4 cycles after the first read; oRDY returns after 9*260 = 2340 cycles.
REQ-040 iSTART during pass 3 -> no effect; reset asserted in pass 5 -> immediate IDLE, no writes; restart -> pass 0.
REQ-041 FHT_COEF_QUARTER_EN, pass 8, k=200 -> oADDR_COEF=56 and fold flag=1; without the macro -> oADDR_COEF=200 and flag=0.
